// File: rtl/kcpsm6_int_pkg.sv
// kcpsm6_int_pkg
// Shared definitions for the KCPSM6 interrupt controller: register offsets,
// FSM state encoding, VECTOR register layout and a source-mask helper.
package kcpsm6_int_pkg;

  // Register offsets relative to BASE_PORT
  localparam logic [2:0] REG_STATUS = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_CLEAR  = 3'd2;
  localparam logic [2:0] REG_VECTOR = 3'd3;
  localparam logic [2:0] REG_SWTRIG = 3'd4;

  // VECTOR register layout: {in_service, 4'b0, active_idx[2:0]}
  localparam int VEC_INSVC_BIT = 7;
  localparam int VEC_IDX_LSB   = 0;
  localparam int VEC_IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } int_state_e;

  // Bit mask with the low n bits set (n in 1..8)
  function automatic logic [7:0] src_mask(input int n);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/prio_enc8.sv
// prio_enc8
// Combinational lowest-index priority encoder over 8 request bits.
// Ports:
//   req   in  8  request vector
//   idx   out 3  index of lowest set request (0 when none)
//   valid out 1  at least one request set
module prio_enc8 (
  input  logic [7:0] req,
  output logic [2:0] idx,
  output logic       valid
);

  always_comb begin
    idx   = 3'd0;
    valid = |req;
    // Scan downward so the lowest set bit is the last assignment
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/kcpsm6_int_ctrl.sv
// kcpsm6_int_ctrl
// Interrupt controller for the KCPSM6 subsystem. Captures rising edges on up
// to eight sources into pending bits, gates requests with a mask, raises the
// processor interrupt for the lowest pending enabled source and tracks the
// acknowledge/service handshake.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   port_id         processor port address
//   out_port        processor write data
//   write_strobe    write qualifier
//   read_strobe     read qualifier (reads have no side effects)
//   rd_data         registered read data, 0 outside the block's range
//   irq_src         interrupt sources (synchronous to clk)
//   interrupt       to processor
//   interrupt_ack   from processor
module kcpsm6_int_ctrl
  import kcpsm6_int_pkg::*;
#(
  parameter int         NUM_SOURCES = 8,
  parameter logic [7:0] BASE_PORT   = 8'h40
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             port_id,
  input  logic [7:0]             out_port,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  output logic [7:0]             rd_data,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic                   interrupt,
  input  logic                   interrupt_ack
);

  localparam logic [7:0] SRC_MASK = src_mask(NUM_SOURCES);

  // Reads have no side effects, so the read qualifier is not needed here
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  logic [7:0] src_w;
  logic [7:0] src_q, edge_q, pending_q, mask_q;
  logic [7:0] wr_clear, wr_swtrig, pending_d, req;
  logic [7:0] rd_next;
  logic       blk_hit;
  logic [2:0] off;
  logic [2:0] idx_q, idx_d, enc_idx;
  logic       enc_vld;
  int_state_e state_q, state_d;

  assign src_w   = 8'(irq_src) & SRC_MASK;
  assign blk_hit = (port_id[7:3] == BASE_PORT[7:3]);
  assign off     = port_id[2:0];

  assign wr_clear  = (write_strobe && blk_hit && off == REG_CLEAR)  ? (out_port & SRC_MASK) : 8'h00;
  assign wr_swtrig = (write_strobe && blk_hit && off == REG_SWTRIG) ? (out_port & SRC_MASK) : 8'h00;

  // Set sources are OR-ed after the clear so a same-cycle set wins
  assign pending_d = (pending_q & ~wr_clear) | edge_q | wr_swtrig;

  // Mask only gates request generation, never capture
  assign req = pending_q & mask_q;

  prio_enc8 u_prio (
    .req   (req),
    .idx   (enc_idx),
    .valid (enc_vld)
  );

  // Edge detect is registered: sample at edge N, pending set at edge N+1
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q     <= 8'h00;
      edge_q    <= 8'h00;
      pending_q <= 8'h00;
      mask_q    <= 8'h00;
    end else begin
      src_q     <= src_w;
      edge_q    <= src_w & ~src_q;
      pending_q <= pending_d;
      if (write_strobe && blk_hit && off == REG_MASK)
        mask_q <= out_port & SRC_MASK;
    end
  end

  // Read mux, registered every cycle from port_id
  always_comb begin
    rd_next = 8'h00;
    if (blk_hit) begin
      case (off)
        REG_STATUS: rd_next = pending_q;
        REG_MASK:   rd_next = mask_q;
        REG_VECTOR: begin
          rd_next[VEC_INSVC_BIT]                   = (state_q == ST_SERVICE);
          rd_next[VEC_IDX_LSB +: VEC_IDX_W]        = idx_q;
        end
        default:    rd_next = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data <= 8'h00;
    else       rd_data <= rd_next;
  end

  // FSM next state; active index only moves on IDLE->ASSERT
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_vld) begin
          idx_d   = enc_idx;
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (interrupt_ack) state_d = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (!pending_q[idx_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Decoded straight from the state register, so it is glitch-free
  assign interrupt = (state_q == ST_ASSERT);

endmodule
